// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// geometry used by the receiver, transmitter and baud generator.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// Host-side receive interface: the received byte, its ready flag,
// the error flags, and the host acknowledge that clears them.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 rdy_clr;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    // Receiver side: produces the byte and the status flags.
    modport master (
        output data, rdy, frame_err, overrun, busy,
        input  rdy_clr
    );

    // Host side: consumes the byte and acknowledges it.
    modport slave (
        input  data, rdy, frame_err, overrun, busy,
        output rdy_clr
    );

endinterface : uart_rx_if

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL is the level presented while in reset (the input's idle level).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values of the two stages: input into the first, first into the second.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so each stage captures the other's pre-edge
            // value; blocking here would collapse the chain into a single flop.
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling strobe. Validates the start
// bit at mid-bit, samples DATA_BITS bits LSB-first at mid-bit, checks the
// stop bit and presents the byte with sticky framing/overrun flags.
// OVERSAMPLE must be even and at least 4.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_en,
    input  logic        rx,
    uart_rx_if.master   host
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q,      state_d;
    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic [DATA_BITS-1:0] data_q,       data_d;
    logic                 rdy_q,        rdy_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 overrun_q,    overrun_d;
    logic                 busy_q,       busy_d;

    // Bring the asynchronous line into the clk domain; idle level is 1.
    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state logic: host acknowledge in any cycle, FSM only on ticks.
    always_comb begin
        // NOTE: every signal takes its held value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        rdy_d        = rdy_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;

        // Acknowledge first so a same-cycle set event below overrides it.
        if (host.rdy_clr) begin
            rdy_d       = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if (rx_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d      = START;
                        sample_cnt_d = '0;
                    end
                end

                START: begin
                    if (sample_cnt_q == CNT_MID) begin
                        sample_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end else begin
                            // Too short to be a start bit: ignore it.
                            state_d = IDLE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (sample_cnt_q == CNT_LAST) begin
                        sample_cnt_d = '0;
                        shift_d      = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_d    = bit_idx_q + 1'b1;
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (sample_cnt_q == CNT_LAST) begin
                        sample_cnt_d = '0;
                        state_d      = IDLE;
                        if (rx_s) begin
                            data_d = shift_q;
                            rdy_d  = 1'b1;
                            if (rdy_q && !host.rdy_clr) begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // Register FSM state, counters and all host-visible outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            rdy_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            rdy_q        <= rdy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign host.data      = data_q;
    assign host.rdy       = rdy_q;
    assign host.frame_err = frame_err_q;
    assign host.overrun   = overrun_q;
    assign host.busy      = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framed bytes, a start-bit glitch, a framing
// error, back-to-back overrun, mid-frame reset and a same-cycle acknowledge.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 64;   // 16 ticks x 4 clks

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_en = 1'b0;
    logic rx = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) rx_if ();

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_en (rx_en),
        .rx    (rx),
        .host  (rx_if)
    );

    int vectors = 0;
    int miscompares = 0;
    int div = 0;
    int clr_at = -1;     // frame clk index at which to pulse rdy_clr, -1 = none
    int rdy_rise = -1;   // frame clk index where rdy was first seen rising

    always #5 clk = ~clk;

    // One-clk rx_en strobe every 4 clks, changed just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            div   = (div + 1) % 4;
            rx_en = (div == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a whole frame (start, LSB-first data, stop) aligned to the tick phase.
    // abort_at >= 0 returns early at that clk index of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_at);
        logic [9:0] bits;
        logic       rdy_prev;
        int         idx;
        bits     = {stop, b, 1'b0};
        idx      = 0;
        rdy_prev = rx_if.rdy;
        rdy_rise = -1;
        while (div != 0) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < BIT_CLKS; c++) begin
                if (idx == abort_at) begin
                    rx_if.rdy_clr = 1'b0;
                    return;
                end
                rx_if.rdy_clr = (idx == clr_at);
                @(negedge clk);
                idx++;
                if (!rdy_prev && rx_if.rdy && rdy_rise < 0) rdy_rise = idx;
                rdy_prev = rx_if.rdy;
            end
        end
        rx_if.rdy_clr = 1'b0;
        rx = 1'b1;
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    task automatic pulse_clr();
        rx_if.rdy_clr = 1'b1;
        @(negedge clk);
        rx_if.rdy_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int clr_5a;
        rx_if.rdy_clr = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_data", rx_if.data, 32'h00);
        check("rst_rdy", rx_if.rdy, 1'b0);
        check("rst_frame_err", rx_if.frame_err, 1'b0);
        check("rst_overrun", rx_if.overrun, 1'b0);
        check("rst_busy", rx_if.busy, 1'b0);
        reset = 1'b0;
        idle(2 * BIT_CLKS);

        // Clean frame 0xA5.
        send_frame(8'hA5, 1'b1, -1);
        check("a5_data", rx_if.data, 32'hA5);
        check("a5_rdy", rx_if.rdy, 1'b1);
        check("a5_frame_err", rx_if.frame_err, 1'b0);
        check("a5_overrun", rx_if.overrun, 1'b0);
        check("a5_busy", rx_if.busy, 1'b0);
        pulse_clr();
        check("a5_clr_rdy", rx_if.rdy, 1'b0);

        // Start-bit glitch of 3 ticks.
        while (div != 0) @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_busy_hi", rx_if.busy, 1'b1);
        idle(2 * BIT_CLKS);
        check("glitch_busy_lo", rx_if.busy, 1'b0);
        check("glitch_rdy", rx_if.rdy, 1'b0);
        check("glitch_data", rx_if.data, 32'hA5);
        check("glitch_frame_err", rx_if.frame_err, 1'b0);

        // Framing error on 0x3C.
        send_frame(8'h3C, 1'b0, -1);
        idle(2 * BIT_CLKS);
        check("fe_frame_err", rx_if.frame_err, 1'b1);
        check("fe_data", rx_if.data, 32'hA5);
        check("fe_rdy", rx_if.rdy, 1'b0);
        check("fe_busy", rx_if.busy, 1'b0);
        pulse_clr();
        check("fe_clr", rx_if.frame_err, 1'b0);

        // Back-to-back 0x11, 0x22 without acknowledge.
        send_frame(8'h11, 1'b1, -1);
        check("b2b_first_data", rx_if.data, 32'h11);
        check("b2b_first_overrun", rx_if.overrun, 1'b0);
        send_frame(8'h22, 1'b1, -1);
        check("b2b_data", rx_if.data, 32'h22);
        check("b2b_rdy", rx_if.rdy, 1'b1);
        check("b2b_overrun", rx_if.overrun, 1'b1);
        pulse_clr();
        check("b2b_clr_rdy", rx_if.rdy, 1'b0);
        check("b2b_clr_overrun", rx_if.overrun, 1'b0);

        // Reset in the middle of bit 4 of 0xFF.
        send_frame(8'hFF, 1'b1, 5 * BIT_CLKS + 32);
        check("mid_busy", rx_if.busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_data", rx_if.data, 32'h00);
        check("mid_rst_rdy", rx_if.rdy, 1'b0);
        check("mid_rst_busy", rx_if.busy, 1'b0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        idle(2 * BIT_CLKS);
        check("post_rst_busy", rx_if.busy, 1'b0);
        check("post_rst_rdy", rx_if.rdy, 1'b0);
        send_frame(8'h5A, 1'b1, -1);
        check("5a_data", rx_if.data, 32'h5A);
        check("5a_rdy", rx_if.rdy, 1'b1);
        check("5a_rise_seen", (rdy_rise > 0), 1'b1);
        clr_5a = rdy_rise - 1;
        idle(BIT_CLKS);

        // Acknowledge in the same clk as completion of 0x7E: the set wins.
        clr_at = clr_5a;
        send_frame(8'h7E, 1'b1, -1);
        clr_at = -1;
        check("same_clk_rdy", rx_if.rdy, 1'b1);
        check("same_clk_data", rx_if.data, 32'h7E);
        check("same_clk_overrun", rx_if.overrun, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_rx
